// File: rtl/inv_subbytes_seq_if.sv
// inv_subbytes_seq_if: valid/ready bus carrying one 128-bit AES state into and out of the InvSubBytes engine.
// Signals:
//   in_valid/in_ready/in_state     block offered to the engine (byte 0 = [127:120])
//   out_valid/out_ready/out_state  substituted block returned by the engine
//   busy                           engine is working on or holding a block
// Modports: slave = engine side, master = producer/consumer side.
interface inv_subbytes_seq_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;
    modport slave (
        input  in_valid, in_state, out_ready,
        output in_ready, out_valid, out_state, busy
    );
    modport master (
        output in_valid, in_state, out_ready,
        input  in_ready, out_valid, out_state, busy
    );
endinterface

// File: rtl/inv_subbytes_seq.sv
// inv_subbytes_seq: iterative AES InvSubBytes, BYTES_PER_CYCLE shared inverse S-boxes over NUM_STEPS busy cycles.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    inv_subbytes_seq_if.slave: input handshake, output handshake, busy flag
module inv_subbytes_seq #(
    parameter int BYTES_PER_CYCLE = 4
) (
    input logic               clk,
    input logic               rst_n,
    inv_subbytes_seq_if.slave bus
);
    localparam int NUM_STEPS = 16 / BYTES_PER_CYCLE;
    localparam int W         = 8 * BYTES_PER_CYCLE;
    localparam int CW        = NUM_STEPS > 1 ? $clog2(NUM_STEPS) : 1;

    if (BYTES_PER_CYCLE != 1 && BYTES_PER_CYCLE != 2 && BYTES_PER_CYCLE != 4 &&
        BYTES_PER_CYCLE != 8 && BYTES_PER_CYCLE != 16) begin : g_bad_param
        $error("inv_subbytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [127:0]    work_q, work_d;
    logic [W-1:0]    grp, sub;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = p ^ (b[i] ? x : 8'h00);
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Inverse affine transform, then multiplicative inverse as x^254 (0 maps to 0 naturally).
    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] a;
        logic [7:0] r;
        a = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
        r = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            r = gf_mul(r, r);
            if (i != 0) r = gf_mul(r, a);
        end
        return r;
    endfunction

    // Select the byte group addressed by the step counter; group 0 is the most significant.
    always_comb begin
        grp = '0;
        for (int g = 0; g < NUM_STEPS; g++)
            if (cnt_q == CW'(g)) grp = work_q[127-W*g -: W];
    end

    always_comb begin
        sub = '0;
        for (int j = 0; j < BYTES_PER_CYCLE; j++)
            sub[W-1-8*j -: 8] = inv_sbox(grp[W-1-8*j -: 8]);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                work_d  = bus.in_state;
                cnt_d   = '0;
                state_d = BUSY;
            end
            BUSY: begin
                for (int g = 0; g < NUM_STEPS; g++)
                    if (cnt_q == CW'(g)) work_d[127-W*g -: W] = sub;
                if (cnt_q == CW'(NUM_STEPS - 1)) state_d = DONE;
                else cnt_d = cnt_q + CW'(1);
            end
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
        end
    end

    // Qualify with rst_n so the engine never advertises readiness while held in reset.
    assign bus.in_ready  = rst_n && state_q == IDLE;
    assign bus.out_valid = state_q == DONE;
    assign bus.out_state = work_q;
    assign bus.busy      = state_q != IDLE;
endmodule

// File: tb/tb_inv_subbytes_seq.sv
// tb_inv_subbytes_seq: scoreboard bench driving three engines (1, 4 and 16 bytes per cycle) in parallel.
module tb_inv_subbytes_seq;
    typedef struct {
        logic [127:0] inp;
        logic [127:0] exp;
        int           t;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [2:0]   in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0] in_state [3];
    logic [127:0] out_state [3];
    logic [2:0]   prev_ov;
    logic [127:0] prev_os [3];
    logic [7:0]   fwd_t [256];
    logic [7:0]   inv_t [256];
    exp_t         sb [3][$];
    int           cyc = 0;
    int           tests = 0;
    int           fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : u
        inv_subbytes_seq_if bus ();
        assign bus.in_valid  = in_valid[g];
        assign bus.in_state  = in_state[g];
        assign bus.out_ready = out_ready[g];
        assign in_ready[g]   = bus.in_ready;
        assign out_valid[g]  = bus.out_valid;
        assign out_state[g]  = bus.out_state;
        assign busy[g]       = bus.busy;
        inv_subbytes_seq #(.BYTES_PER_CYCLE(g == 0 ? 1 : g == 1 ? 4 : 16)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
    end

    function automatic int ns(input int i);
        return i == 0 ? 16 : i == 1 ? 4 : 1;
    endfunction

    function automatic void chk(input string n, input int i, input logic [127:0] a, input logic [127:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s dut%0d: got %h expected %h", n, i, a, e);
        end
    endfunction

    function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    // Forward S-box from a brute-force field inverse plus the forward affine map; inverse table by inversion.
    task automatic build_tables();
        logic [7:0] v;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            v = 8'h00;
            for (int y = 1; y < 256; y++)
                if (tb_mul(8'(x), 8'(y)) == 8'h01) v = 8'(y);
            s = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
            fwd_t[x] = s;
            inv_t[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        for (int l = 0; l < 16; l++) r[127-8*l -: 8] = fwd_t[s[127-8*l -: 8]];
        return r;
    endfunction

    function automatic logic [127:0] inv_bytes(input logic [127:0] s);
        logic [127:0] r;
        for (int l = 0; l < 16; l++) r[127-8*l -: 8] = inv_t[s[127-8*l -: 8]];
        return r;
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input int i, input logic [127:0] d, input logic [127:0] e);
        int n;
        exp_t x;
        in_state[i] = d;
        in_valid[i] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready[i] && n < 500);
        if (in_ready[i]) begin
            x.inp = d;
            x.exp = e;
            x.t   = cyc + 1;
            sb[i].push_back(x);
        end else chk("send_timeout", i, 128'(in_ready[i]), 128'd1);
        @(posedge clk);
        #1 in_valid[i] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb[0].size() + sb[1].size() + sb[2].size()) != 0 && n < 2000) begin
            @(posedge clk);
            #1 n++;
        end
        if (n >= 2000) chk("drain_timeout", 0, 128'(sb[0].size() + sb[1].size() + sb[2].size()), 128'd0);
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) prev_ov[i] = 1'b0;
            else begin
                if (out_valid[i] && !prev_ov[i]) begin
                    if (sb[i].size() == 0) chk("unexpected_output", i, out_state[i], 128'hx);
                    else chk("latency", i, 128'(cyc), 128'(sb[i][0].t + ns(i)));
                end
                if (out_valid[i] && prev_ov[i]) chk("stall_stable", i, out_state[i], prev_os[i]);
                if (out_valid[i] && out_ready[i] && sb[i].size() != 0) begin
                    exp_t e;
                    e = sb[i].pop_front();
                    chk("out_state", i, out_state[i], e.exp);
                    chk("roundtrip", i, sub_bytes(out_state[i]), e.inp);
                end
                prev_ov[i] = out_valid[i];
                prev_os[i] = out_state[i];
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] d;
        int n;
        build_tables();
        in_valid  = '0;
        out_ready = '1;
        for (int i = 0; i < 3; i++) in_state[i] = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_in_ready", i, 128'(in_ready[i]), 128'd1);
            chk("rst_out_valid", i, 128'(out_valid[i]), 128'd0);
            chk("rst_busy", i, 128'(busy[i]), 128'd0);
            chk("rst_out_state", i, out_state[i], 128'd0);
        end

        for (int i = 0; i < 3; i++) begin
            send(i, 128'h637c777bf26b6fc53001672bfed7ab76, 128'h000102030405060708090a0b0c0d0e0f);
            send(i, {16{8'h00}}, {16{8'h52}});
            send(i, {16{8'h16}}, {16{8'hff}});
            send(i, {16{8'h52}}, {16{8'h48}});
            send(i, {16{8'h63}}, {16{8'h00}});
            send(i, {16{8'h7c}}, {16{8'h01}});
        end
        drain();

        out_ready[1] = 1'b0;
        send(1, 128'h637c777bf26b6fc53001672bfed7ab76, 128'h000102030405060708090a0b0c0d0e0f);
        n = 0;
        while (!out_valid[1] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_reach_done", 1, 128'(out_valid[1]), 128'd1);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1 in_valid[1] = k[0] ? 1'b0 : 1'b1;
            in_state[1] = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            chk("bp_in_ready", 1, 128'(in_ready[1]), 128'd0);
            chk("bp_out_valid", 1, 128'(out_valid[1]), 128'd1);
        end
        @(posedge clk);
        #1 in_valid[1] = 1'b0;
        out_ready[1] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release_out_valid", 1, 128'(out_valid[1]), 128'd0);
        chk("bp_release_in_ready", 1, 128'(in_ready[1]), 128'd1);
        repeat (3) @(negedge clk);
        chk("bp_no_capture", 1, 128'(busy[1]), 128'd0);
        @(posedge clk);
        #1 drain();

        send(1, 128'h0123456789abcdeffedcba9876543210, 128'hx);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 1, 128'(in_ready[1]), 128'd0);
        chk("midrst_out_valid", 1, 128'(out_valid[1]), 128'd0);
        chk("midrst_busy", 1, 128'(busy[1]), 128'd0);
        chk("midrst_out_state", 1, out_state[1], 128'd0);
        sb[1].delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1 send(1, {16{8'h52}}, {16{8'h48}});
        drain();

        for (int b = 0; b < 256; b++) begin
            for (int l = 0; l < 16; l++) d[127-8*l -: 8] = 8'(b + 17 * l);
            for (int i = 0; i < 3; i++) send(i, d, inv_bytes(d));
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
